jtag_dbg_cmd_bridge: RTL and testbench

System-clock side of the CPU JTAG debug path, generalised from the fixed 38-bit, 2-bit-IR sysclk module. It synchronises the update-DR and update-IR strobes from the TCK domain and captures the scan register into `jdo`. It then presents each debug command to the CPU debug core over a valid/ready handshake, raising one-hot take-action or take-no-action strobes. Commands that arrive while one is still pending are detected and flagged as overruns, which the previous generation could not do.

---
 rtl/jtag_dbg_pkg.sv | 20 ++
 rtl/jtag_dbg_sync_edge.sv | 31 +++
 rtl/jtag_dbg_cmd_bridge.sv | 123 ++++++++++++
 tb/tb_jtag_dbg_cmd_bridge.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dbg_pkg.sv
// Shared types and constants for the JTAG debug command bridge.
package jtag_dbg_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int ACT_BIT_DEF   = 34;
  localparam int SYNC_MIN      = 2;
  localparam int SYNC_MAX      = 4;

  // Out-of-range synchroniser depths are clamped to the supported range.
  function automatic int sync_depth(input int n);
    if (n < SYNC_MIN) return SYNC_MIN;
    if (n > SYNC_MAX) return SYNC_MAX;
    return n;
  endfunction

endpackage

// File: rtl/jtag_dbg_sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector; evt is a
// one-cycle pulse decoded from registers only.
module jtag_dbg_sync_edge
  import jtag_dbg_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic evt
);

  localparam int N = sync_depth(STAGES);

  logic [N-1:0] chain;
  logic         prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[N-2:0], din};
      prev  <= chain[N-1];
    end
  end

  assign evt = chain[N-1] & ~prev;

endmodule

// File: rtl/jtag_dbg_cmd_bridge.sv
// System-clock side of the JTAG debug path: synchronises update-DR/IR,
// captures the scan register and hands commands to the debug core via
// valid/ready. Optional saturating drop counter under JTAG_DBG_OVERRUN_CNT_EN.
module jtag_dbg_cmd_bridge
  import jtag_dbg_pkg::*;
#(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int ACT_BIT     = ACT_BIT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SR_W-1:0]      sr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic                 cmd_ready,
  input  logic                 clr_overrun,
  output logic [SR_W-1:0]      jdo,
  output logic [IR_W-1:0]      cmd_ir,
  output logic                 cmd_valid,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
`ifdef JTAG_DBG_OVERRUN_CNT_EN
  output logic [7:0]           overrun_cnt,
`endif
  output logic                 overrun
);

  localparam int NCH = 2**IR_W;

  logic            udr_evt;
  logic            uir_evt;
  logic [IR_W-1:0] ir_q;
  state_t          state;
  logic            xfer;
  logic            drop;

  jtag_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk   (clk),
    .reset (reset),
    .din   (vs_udr),
    .evt   (udr_evt)
  );

  jtag_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk   (clk),
    .reset (reset),
    .din   (vs_uir),
    .evt   (uir_evt)
  );

  assign xfer = cmd_valid & cmd_ready;
  assign drop = (state == PENDING) & udr_evt & ~xfer;

  // Captures always use the registered ir_q, so a same-cycle IR update
  // only affects later commands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ir_q      <= '0;
      jdo       <= '0;
      cmd_ir    <= '0;
      cmd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (uir_evt) ir_q <= ir_in;

      case (state)
        IDLE: begin
          if (udr_evt) begin
            jdo       <= sr;
            cmd_ir    <= ir_q;
            cmd_valid <= 1'b1;
            state     <= PENDING;
          end
        end
        PENDING: begin
          if (xfer) begin
            if (udr_evt) begin
              jdo    <= sr;
              cmd_ir <= ir_q;
            end else begin
              cmd_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase

      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

`ifdef JTAG_DBG_OVERRUN_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_cnt <= '0;
    end else if (drop) begin
      if (clr_overrun)              overrun_cnt <= 8'd1;
      else if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end else if (clr_overrun) begin
      overrun_cnt <= '0;
    end
  end
`endif

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    for (int i = 0; i < NCH; i++) begin
      take_action[i]    = xfer & (cmd_ir == IR_W'(i)) &  jdo[ACT_BIT];
      take_no_action[i] = xfer & (cmd_ir == IR_W'(i)) & ~jdo[ACT_BIT];
    end
  end

endmodule

// File: tb/tb_jtag_dbg_cmd_bridge.sv
// Directed self-checking bench for jtag_dbg_cmd_bridge (default parameters).
// Counter checks are compiled in when JTAG_DBG_OVERRUN_CNT_EN is defined.
module tb_jtag_dbg_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] sr = '0;
  logic [1:0]  ir_in = '0;
  logic        vs_udr = 1'b0;
  logic        vs_uir = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [37:0] jdo;
  logic [1:0]  cmd_ir;
  logic        cmd_valid;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        overrun;
`ifdef JTAG_DBG_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  jtag_dbg_cmd_bridge dut (
    .clk            (clk),
    .reset          (reset),
    .sr             (sr),
    .ir_in          (ir_in),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .cmd_ready      (cmd_ready),
    .clr_overrun    (clr_overrun),
    .jdo            (jdo),
    .cmd_ir         (cmd_ir),
    .cmd_valid      (cmd_valid),
    .take_action    (take_action),
    .take_no_action (take_no_action),
`ifdef JTAG_DBG_OVERRUN_CNT_EN
    .overrun_cnt    (overrun_cnt),
`endif
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  // Raise vs_udr for one cycle; returns at the negedge after its first sample.
  task automatic udr_pulse();
    vs_udr = 1'b1;
    @(negedge clk);
    vs_udr = 1'b0;
  endtask

  task automatic load_ir(input logic [1:0] v);
    @(negedge clk);
    ir_in  = v;
    vs_uir = 1'b1;
    @(negedge clk);
    vs_uir = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    n_checks++; if (jdo !== 38'h0) begin n_fail++; $display("FAIL reset_jdo got %h want 0", jdo); end
    n_checks++; if (cmd_ir !== 2'd0) begin n_fail++; $display("FAIL reset_cmd_ir got %0d want 0", cmd_ir); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_checks++; if ((take_action | take_no_action) !== 4'b0) begin n_fail++; $display("FAIL reset_strobes got %b/%b want 0", take_action, take_no_action); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_action();
    load_ir(2'd2);
    sr = 38'h04_0000_1234;
    cmd_ready = 1'b1;
    udr_pulse();
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL act_lat_e1 got %b want 0", cmd_valid); end
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL act_lat_e2 got %b want 0", cmd_valid); end
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL act_lat_e3 got %b want 1", cmd_valid); end
    n_checks++; if (take_action !== 4'b0100) begin n_fail++; $display("FAIL act_take_action got %b want 0100", take_action); end
    n_checks++; if (take_no_action !== 4'b0000) begin n_fail++; $display("FAIL act_take_no_action got %b want 0000", take_no_action); end
    n_checks++; if (jdo !== 38'h04_0000_1234) begin n_fail++; $display("FAIL act_jdo got %h want 0400001234", jdo); end
    n_checks++; if (cmd_ir !== 2'd2) begin n_fail++; $display("FAIL act_cmd_ir got %0d want 2", cmd_ir); end
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0 || take_action !== 4'b0) begin n_fail++; $display("FAIL act_after_xfer got valid=%b ta=%b want 0/0000", cmd_valid, take_action); end
    n_checks++; if (jdo !== 38'h04_0000_1234) begin n_fail++; $display("FAIL act_jdo_hold got %h want 0400001234", jdo); end
    cmd_ready = 1'b0;
  endtask

  task automatic test_no_action();
    load_ir(2'd0);
    sr = 38'h00_0000_5678;
    cmd_ready = 1'b1;
    udr_pulse();
    repeat (2) @(negedge clk);
    n_checks++; if (take_no_action !== 4'b0001) begin n_fail++; $display("FAIL noact_take_no_action got %b want 0001", take_no_action); end
    n_checks++; if (take_action !== 4'b0000) begin n_fail++; $display("FAIL noact_take_action got %b want 0000", take_action); end
    n_checks++; if (jdo !== 38'h00_0000_5678) begin n_fail++; $display("FAIL noact_jdo got %h want 0000005678", jdo); end
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic test_overrun();
    cmd_ready = 1'b0;
    sr = 38'h3F_0000_0001;
    udr_pulse();
    repeat (2) @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid got %b want 1", cmd_valid); end
    n_checks++; if (take_action !== 4'b0000) begin n_fail++; $display("FAIL ovr_no_strobe got %b want 0000", take_action); end
    sr = 38'h00_1111_2222;
    udr_pulse();
    repeat (2) @(negedge clk);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", overrun); end
    n_checks++; if (jdo !== 38'h3F_0000_0001) begin n_fail++; $display("FAIL ovr_jdo_kept got %h want 3F00000001", jdo); end
`ifdef JTAG_DBG_OVERRUN_CNT_EN
    n_checks++; if (overrun_cnt !== 8'd1) begin n_fail++; $display("FAIL ovr_cnt got %0d want 1", overrun_cnt); end
`endif
    clr_overrun = 1'b1;
    cmd_ready   = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    cmd_ready   = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drained got %b want 0", cmd_valid); end
  endtask

  task automatic test_back_to_back();
    cmd_ready = 1'b0;
    sr = 38'h04_AAAA_0000;
    udr_pulse();
    repeat (2) @(negedge clk);
    sr = 38'h00_5555_0000;
    udr_pulse();
    @(negedge clk);
    cmd_ready = 1'b1;
    #1;
    n_checks++; if (take_action !== 4'b0001) begin n_fail++; $display("FAIL b2b_first_strobe got %b want 0001", take_action); end
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_held got %b want 1", cmd_valid); end
    n_checks++; if (jdo !== 38'h00_5555_0000) begin n_fail++; $display("FAIL b2b_jdo got %h want 0055550000", jdo); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    n_checks++; if (take_no_action !== 4'b0001) begin n_fail++; $display("FAIL b2b_second_strobe got %b want 0001", take_no_action); end
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %b want 0", cmd_valid); end
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    sr = 38'h15_0F0F_0F0F;
    udr_pulse();
    repeat (2) @(negedge clk);
    vs_udr = 1'b1;
    reset  = 1'b1;
    #1;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", cmd_valid); end
    n_checks++; if (jdo !== 38'h0) begin n_fail++; $display("FAIL rmid_jdo got %h want 0", jdo); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_e1 got %b want 0", cmd_valid); end
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_e2 got %b want 0", cmd_valid); end
    @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_e3 got %b want 1", cmd_valid); end
    n_checks++; if (jdo !== 38'h15_0F0F_0F0F) begin n_fail++; $display("FAIL rmid_jdo_cap got %h want 150F0F0F0F", jdo); end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (cmd_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_single got valid=%b ovr=%b want 0/0", cmd_valid, overrun); end
    vs_udr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef JTAG_DBG_OVERRUN_CNT_EN
  task automatic test_overrun_sat();
    cmd_ready = 1'b0;
    udr_pulse();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      vs_udr = 1'b1;
      @(negedge clk);
      vs_udr = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_checks++; if (overrun_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt got %0d want 255", overrun_cnt); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b want 1", overrun); end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clear got %0d want 0", overrun_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_action();
    test_no_action();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef JTAG_DBG_OVERRUN_CNT_EN
    test_overrun_sat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
